sound_player: RTL and testbench

SOUND_PLAYER -- requirements
Module: sound_player

---
 rtl/sound_player_if.sv | 20 ++
 rtl/sound_player.sv | 112 +++++++++++
 tb/tb_sound_player.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sound_player_if.sv
// Request/status bundle between a sound requester and sound_player.
// The master drives requests and mute; the slave (player) drives the audio and status.
interface sound_player_if;
  logic       playsound;
  logic [1:0] soundselector;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic       done;

  modport master (
    output playsound, soundselector, mute,
    input  speaker, busy, done
  );

  modport slave (
    input  playsound, soundselector, mute,
    output speaker, busy, done
  );
endinterface

// File: rtl/sound_player.sv
// Four-entry square-wave jingle player: each sound is a short sequence of tone slots,
// each slot lasting NOTE_LEN cycles with a half-period picked by a 3-bit tone code.
module sound_player #(
  parameter int NOTE_LEN  = 5_000_000,
  parameter int TONE_UNIT = 4_000
) (
  input  logic           clk,
  input  logic           reset,
  sound_player_if.slave  bus
);

  localparam int NW = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam int TW = (7 * TONE_UNIT > 1) ? $clog2(7 * TONE_UNIT) : 1;
  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_LEN - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    note_idx_q, note_idx_d;
  logic [NW-1:0] note_cnt_q, note_cnt_d;
  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          spk_q, spk_d;
  logic          done_q, done_d;

  logic [2:0]    tone_code;
  logic [TW-1:0] hp_last;

  always_comb begin
    tone_code = 3'd0;
    case (sel_q)
      2'd0: tone_code = 3'd6;
      2'd1: tone_code = (note_idx_q == 2'd0) ? 3'd4 : 3'd6;
      2'd2: tone_code = 3'(3 - int'(note_idx_q));
      2'd3: tone_code = 3'(4 + int'(note_idx_q));
      default: tone_code = 3'd0;
    endcase
  end

  always_comb begin
    hp_last = TW'((8 - int'(tone_code)) * TONE_UNIT - 1);
  end

  // Sound length is sel+1 slots, so the last slot index equals the latched code.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    note_idx_d = note_idx_q;
    note_cnt_d = note_cnt_q;
    tone_cnt_d = tone_cnt_q;
    spk_d      = spk_q;
    done_d     = 1'b0;

    if (bus.playsound) begin
      state_d    = PLAY;
      sel_d      = bus.soundselector;
      note_idx_d = 2'd0;
      note_cnt_d = '0;
      tone_cnt_d = '0;
      spk_d      = 1'b0;
    end else if (state_q == PLAY) begin
      if (note_cnt_q == NOTE_LAST) begin
        note_cnt_d = '0;
        tone_cnt_d = '0;
        spk_d      = 1'b0;
        if (note_idx_q == sel_q) begin
          state_d    = IDLE;
          note_idx_d = 2'd0;
          done_d     = 1'b1;
        end else begin
          note_idx_d = note_idx_q + 2'd1;
        end
      end else begin
        note_cnt_d = note_cnt_q + NW'(1);
        if (tone_code == 3'd0) begin
          tone_cnt_d = '0;
          spk_d      = 1'b0;
        end else if (tone_cnt_q == hp_last) begin
          tone_cnt_d = '0;
          spk_d      = ~spk_q;
        end else begin
          tone_cnt_d = tone_cnt_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      note_idx_q <= 2'd0;
      note_cnt_q <= '0;
      tone_cnt_q <= '0;
      spk_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      note_idx_q <= note_idx_d;
      note_cnt_q <= note_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      spk_q      <= spk_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy    = (state_q == PLAY);
  assign bus.done    = done_q;
  assign bus.speaker = spk_q & ~bus.mute & (state_q == PLAY);

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player: a timeline model pushes expected outputs per cycle
// into a scoreboard queue, which is popped and compared after each clock edge.
module tb_sound_player;

  localparam int NOTE_LEN  = 64;
  localparam int TONE_UNIT = 2;

  typedef struct {
    logic busy;
    logic done;
    logic spk;
  } exp_t;

  logic clk;
  logic reset;
  sound_player_if bus_if ();

  sound_player #(.NOTE_LEN(NOTE_LEN), .TONE_UNIT(TONE_UNIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;
  int   done_seen = 0;
  logic cur_mute = 1'b0;

  int   m_play = 0;
  int   m_sel = 0;
  int   m_slot = 0;
  int   m_t = 0;
  int   m_done = 0;

  function automatic int seq_len(input int s);
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int seq_code(input int s, input int slot);
    int c;
    c = 0;
    case (s)
      0: c = 6;
      1: c = (slot == 0) ? 4 : 6;
      2: case (slot) 0: c = 3; 1: c = 2; default: c = 1; endcase
      default: case (slot) 0: c = 4; 1: c = 5; 2: c = 6; default: c = 7; endcase
    endcase
    return c;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s step=%0d observed=%b expected=%b", tag, step_no, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic ps, input logic [1:0] s, input logic rst);
    exp_t e;
    int   code;
    int   hp;
    bus_if.playsound     = ps;
    bus_if.soundselector = s;
    bus_if.mute          = cur_mute;
    reset                = rst;

    m_done = 0;
    if (rst) begin
      m_play = 0; m_sel = 0; m_slot = 0; m_t = 0;
    end else if (ps) begin
      m_play = 1; m_sel = int'(s); m_slot = 0; m_t = 0;
    end else if (m_play != 0) begin
      if (m_t == NOTE_LEN - 1) begin
        m_t = 0;
        if (m_slot == seq_len(m_sel) - 1) begin
          m_play = 0; m_slot = 0; m_done = 1;
        end else begin
          m_slot++;
        end
      end else begin
        m_t++;
      end
    end

    code   = seq_code(m_sel, m_slot);
    hp     = (8 - code) * TONE_UNIT;
    e.busy = (m_play != 0);
    e.done = (m_done != 0);
    e.spk  = (m_play != 0) && (code != 0) && (((m_t / hp) % 2) == 1) && !cur_mute;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    step_no++;
    e = sb_q.pop_front();
    check_bit("busy", bus_if.busy, e.busy);
    check_bit("done", bus_if.done, e.done);
    check_bit("speaker", bus_if.speaker, e.spk);
    if (bus_if.done === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    bus_if.playsound     = 1'b0;
    bus_if.soundselector = 2'd0;
    bus_if.mute          = 1'b0;
    reset                = 1'b1;

    // Reset state, with a request present to show reset wins
    step(1'b1, 2'd3, 1'b1);
    step(1'b0, 2'd0, 1'b1);
    idle(3);

    // Single UI_PRESS note
    done_seen = 0;
    step(1'b1, 2'd0, 1'b0);
    idle(70);
    check_int("ui_press_done_count", done_seen, 1);

    // Full CELEBRATION sequence
    done_seen = 0;
    step(1'b1, 2'd3, 1'b0);
    idle(260);
    check_int("celebration_done_count", done_seen, 1);

    // NEXTLEVEL preempted by CRASH 70 cycles after accept
    done_seen = 0;
    step(1'b1, 2'd1, 1'b0);
    idle(69);
    step(1'b1, 2'd2, 1'b0);
    idle(200);
    check_int("preempt_done_count", done_seen, 1);

    // Re-request UI_PRESS on its final cycle
    done_seen = 0;
    step(1'b1, 2'd0, 1'b0);
    idle(63);
    step(1'b1, 2'd0, 1'b0);
    check_int("boundary_no_early_done", done_seen, 0);
    idle(70);
    check_int("boundary_done_count", done_seen, 1);

    // Muted CRASH: sequencing unchanged, speaker silent
    done_seen = 0;
    cur_mute = 1'b1;
    step(1'b1, 2'd2, 1'b0);
    idle(200);
    cur_mute = 1'b0;
    check_int("muted_done_count", done_seen, 1);

    // Reset in the middle of slot 1 of CRASH aborts without done
    done_seen = 0;
    step(1'b1, 2'd2, 1'b0);
    idle(90);
    step(1'b0, 2'd0, 1'b1);
    idle(200);
    check_int("reset_abort_done_count", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
